// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller.
// On a fetch miss it reads the four 32-bit words of the missing 16-byte line
// from main memory, one request per beat. It then installs the assembled line
// into the cache with a single-cycle write strobe. The pipeline is stalled
// while a refill is in flight. A memory beat that never completes parks the
// block in a sticky error state that only reset can clear.
module icache_refill_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fetch_valid,
    input  logic [31:0]  fetch_addr,
    input  logic         hit,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rdata,
    output logic [127:0] line_data,
    output logic [31:0]  line_addr,
    output logic         line_valid,
    output logic         stall,
    output logic         err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    logic [1:0]    r_state;
    logic [1:0]    r_beat;
    logic [TW-1:0] r_tmo;
    logic [31:0]   r_base;
    logic [31:0]   r_mem_addr;
    logic          r_mem_req;
    logic [127:0]  r_line_data;
    logic [31:0]   r_line_addr;
    logic          r_line_valid;
    logic          r_err;

    logic [1:0]    w_next_state;
    logic          w_miss;
    logic          w_beat_last;
    logic          w_timeout;
    logic [1:0]    w_beat_inc;

    assign w_miss      = fetch_valid & ~hit;
    assign w_beat_last = (r_beat == 2'd3);
    assign w_timeout   = (r_tmo == TMO_LAST);
    assign w_beat_inc  = r_beat + 2'd1;

    // Next-state selection for the refill sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_next_state = ST_BURST;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (mem_ready) begin
                    if (w_beat_last) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_next_state = ST_BURST;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_next_state = ST_BURST;
                end
            end
            ST_WRITE: w_next_state = ST_IDLE;
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State, registered strobes, and the line/addr datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= 2'd0;
            r_tmo        <= '0;
            r_base       <= 32'd0;
            r_mem_addr   <= 32'd0;
            r_mem_req    <= 1'b0;
            r_line_data  <= 128'd0;
            r_line_addr  <= 32'd0;
            r_line_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // Strobes are decoded from the next state so they line up with it.
            r_mem_req    <= (w_next_state == ST_BURST);
            r_line_valid <= (w_next_state == ST_WRITE);
            r_err        <= (w_next_state == ST_ERROR);
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_base     <= fetch_addr & LINE_MASK;
                        r_mem_addr <= fetch_addr & LINE_MASK;
                        r_beat     <= 2'd0;
                        r_tmo      <= '0;
                    end
                end
                ST_BURST: begin
                    if (mem_ready) begin
                        r_line_data[{r_beat, 5'd0} +: 32] <= mem_rdata;
                        r_beat <= w_beat_inc;
                        r_tmo  <= '0;
                        if (w_beat_last) begin
                            // mem_addr keeps the final word address after the burst.
                            r_line_addr <= r_base;
                        end else begin
                            r_mem_addr <= r_base + {28'd0, w_beat_inc, 2'b00};
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign line_data  = r_line_data;
    assign line_addr  = r_line_addr;
    assign line_valid = r_line_valid;
    assign err        = r_err;
    // The stall must cover the miss cycle itself, so it is combinational.
    assign stall      = (r_state != ST_IDLE) | w_miss;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl.
// A transaction-level model predicts every output each cycle. The model tracks
// whether a refill is in flight, how many words have arrived, and how long the
// current beat has waited. Directed scenarios are followed by a randomized run.
module tb_icache_refill_ctrl;

    localparam int unsigned TMO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fetch_valid = 1'b0;
    logic [31:0]  fetch_addr = 32'd0;
    logic         hit = 1'b0;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_rdata = 32'd0;
    logic [127:0] line_data;
    logic [31:0]  line_addr;
    logic         line_valid;
    logic         stall;
    logic         err;

    icache_refill_ctrl #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .line_data   (line_data),
        .line_addr   (line_addr),
        .line_valid  (line_valid),
        .stall       (stall),
        .err         (err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int lv_count = 0;
    int lv_cyc   = -1;

    // Reference model: one refill described by words received and wait time.
    bit           m_busy;
    bit           m_wr;
    bit           m_dead;
    int           m_got;
    int           m_wait;
    logic [31:0]  m_base;
    logic [31:0]  m_last;
    logic [31:0]  m_laddr;
    logic [127:0] m_ldata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_busy  = 1'b0;
        m_wr    = 1'b0;
        m_dead  = 1'b0;
        m_got   = 0;
        m_wait  = 0;
        m_base  = 32'd0;
        m_last  = 32'd0;
        m_laddr = 32'd0;
        m_ldata = 128'd0;
    endtask

    // One clock: predict, check at negedge, advance the model at posedge.
    task automatic cycle();
        logic [31:0] e_addr;
        logic        e_stall;
        if (!rst) m_clear();
        e_addr  = m_busy ? (m_base + 32'(m_got) * 32'd4) : m_last;
        if (m_busy) m_last = e_addr;
        e_stall = m_busy || m_wr || m_dead || (fetch_valid && !hit);
        @(negedge clk);
        chk("mem_req",    128'(mem_req),    128'(m_busy));
        chk("mem_addr",   128'(mem_addr),   128'(e_addr));
        chk("stall",      128'(stall),      128'(e_stall));
        chk("line_valid", 128'(line_valid), 128'(m_wr));
        chk("err",        128'(err),        128'(m_dead));
        chk("line_addr",  128'(line_addr),  128'(m_laddr));
        chk("line_data",  line_data,        m_ldata);
        if (line_valid === 1'b1) begin
            lv_count++;
            lv_cyc = cyc;
        end
        @(posedge clk);
        if (!rst) begin
            m_clear();
        end else if (m_dead) begin
            m_dead = 1'b1;
        end else if (m_wr) begin
            m_wr = 1'b0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_ldata[32*m_got +: 32] = mem_rdata;
                m_wait = 0;
                if (m_got == 3) begin
                    m_busy  = 1'b0;
                    m_wr    = 1'b1;
                    m_laddr = m_base;
                end else begin
                    m_got++;
                end
            end else begin
                m_wait++;
                if (m_wait == int'(TMO)) begin
                    m_busy = 1'b0;
                    m_dead = 1'b1;
                end
            end
        end else if (fetch_valid && !hit) begin
            m_busy = 1'b1;
            m_base = fetch_addr & 32'hFFFF_FFF0;
            m_got  = 0;
            m_wait = 0;
        end
        cyc++;
        #1;
    endtask

    logic [31:0] s32 [4];
    int          c0;
    int          rdy_pct;

    // Directed scenarios followed by randomized traffic.
    initial begin
        s32[0] = 32'h0000_7C00;
        s32[1] = 32'hFFFF_FFFF;
        s32[2] = 32'h0000_0000;
        s32[3] = 32'hFFFF_FFFF;
        m_clear();

        // Reset state, with a miss presented during reset.
        rst = 1'b0;
        fetch_valid = 1'b1;
        hit = 1'b0;
        fetch_addr = 32'h0000_0500;
        mem_ready = 1'b1;
        repeat (3) cycle();
        fetch_valid = 1'b0;
        mem_ready = 1'b0;
        cycle();
        rst = 1'b1;

        // Hits only: nothing moves for 20 cycles.
        fetch_valid = 1'b1;
        hit = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fetch_addr = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        // Back-to-back beats, latency, and line contents.
        lv_count = 0;
        fetch_addr = 32'h0000_0008;
        hit = 1'b0;
        mem_ready = 1'b1;
        c0 = cyc;
        cycle();
        fetch_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = s32[i];
            cycle();
        end
        mem_rdata = $urandom;
        cycle();
        cycle();
        chk("s032_lv_count", 128'(lv_count), 128'd1);
        chk("s032_lv_cycle", 128'(lv_cyc), 128'(c0 + 5));
        chk("s032_line", line_data, 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00);
        chk("s032_laddr", 128'(line_addr), 128'd0);

        // Three wait cycles before each beat.
        lv_count = 0;
        fetch_valid = 1'b1;
        fetch_addr = 32'h0000_1234;
        mem_ready = 1'b0;
        cycle();
        fetch_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_ready = 1'b0;
            repeat (3) cycle();
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            cycle();
        end
        mem_ready = 1'b0;
        cycle();
        cycle();
        chk("s034_lv_count", 128'(lv_count), 128'd1);
        chk("s034_laddr", 128'(line_addr), 128'h1230);

        // A new miss during BURST is ignored until the refill finishes.
        lv_count = 0;
        fetch_valid = 1'b1;
        fetch_addr = 32'h0000_0000;
        mem_ready = 1'b1;
        cycle();
        fetch_addr = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            mem_rdata = $urandom;
            cycle();
        end
        cycle();
        fetch_valid = 1'b0;
        chk("s037_addr", 128'(mem_addr), 128'h100);
        for (int i = 0; i < 6; i++) begin
            mem_rdata = $urandom;
            cycle();
        end
        chk("s037_lv_count", 128'(lv_count), 128'd2);
        chk("s037_laddr", 128'(line_addr), 128'h100);

        // Reset in the middle of a burst clears everything without a clock.
        fetch_valid = 1'b1;
        fetch_addr = 32'h0000_0088;
        mem_ready = 1'b1;
        cycle();
        fetch_valid = 1'b0;
        repeat (3) begin
            mem_rdata = $urandom;
            cycle();
        end
        lv_count = 0;
        rst = 1'b0;
        #1;
        chk("s036_req",   128'(mem_req),    128'd0);
        chk("s036_addr",  128'(mem_addr),   128'd0);
        chk("s036_data",  line_data,        128'd0);
        chk("s036_laddr", 128'(line_addr),  128'd0);
        chk("s036_lv",    128'(line_valid), 128'd0);
        chk("s036_err",   128'(err),        128'd0);
        chk("s036_stall", 128'(stall),      128'd0);
        cycle();
        rst = 1'b1;
        fetch_valid = 1'b1;
        fetch_addr = 32'h0000_0044;
        cycle();
        fetch_valid = 1'b0;
        chk("s036_first", 128'(mem_addr), 128'h40);
        repeat (6) begin
            mem_rdata = $urandom;
            cycle();
        end
        chk("s036_lv_count", 128'(lv_count), 128'd1);

        // Memory never answers: timeout into sticky error.
        fetch_valid = 1'b1;
        fetch_addr = $urandom;
        mem_ready = 1'b0;
        cycle();
        fetch_valid = 1'b0;
        repeat (TMO) cycle();
        chk("s035_err", 128'(err), 128'd1);
        for (int i = 0; i < 10; i++) begin
            fetch_valid = 1'($urandom_range(0, 1));
            hit = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("s035_stuck", 128'(err), 128'd1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("s035_cleared", 128'(err), 128'd0);

        // Randomized traffic, including timeouts and recovery by reset.
        for (int i = 0; i < 800; i++) begin
            rdy_pct = (i < 400) ? 80 : 30;
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            fetch_valid = ($urandom_range(0, 3) != 0);
            hit = ($urandom_range(0, 3) != 0);
            fetch_addr = $urandom;
            mem_ready = ($urandom_range(0, 99) < rdy_pct);
            mem_rdata = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
